// File: rtl/sum_of_squares_seq_if.sv
// Purpose : element/result bundle between a stream source and sum_of_squares_seq.
// Latency : n/a (signal bundle only).
// Backpres: none; the source paces elements with in_valid, the result is held while ready=1.
// Ports   : start/in_valid/A flow master->slave; O/ready/done_pulse/busy/overflow flow slave->master.
interface sum_of_squares_seq_if #(
  parameter int W = 4,
  parameter int N = 8
);
  logic         start;       // begin a new vector, clears the accumulator
  logic         in_valid;    // A carries an element this cycle
  logic [W-1:0] A;           // unsigned element
  logic [N-1:0] O;           // running / final sum of squares (mod 2^N)
  logic         ready;       // O holds a final result
  logic         done_pulse;  // one cycle, coincident with ready rising
  logic         busy;        // accumulating
  logic         overflow;    // sticky carry-out of N bits for this vector

  modport master (
    output start, in_valid, A,
    input  O, ready, done_pulse, busy, overflow
  );

  modport slave (
    input  start, in_valid, A,
    output O, ready, done_pulse, busy, overflow
  );
endinterface

// File: rtl/sum_of_squares_seq.sv
// Purpose : accumulates the sum of squares of LEN unsigned W-bit elements into an N-bit result.
// Latency : result (ready + done_pulse) visible one cycle after the LEN-th element is presented.
// Backpres: none; idle cycles (in_valid=0) are absorbed indefinitely, result is held until start/rst.
// Ports   : clk, rst (async, active-high); bus (slave modport) carries start/in_valid/A in and
//           O/ready/done_pulse/busy/overflow out.
module sum_of_squares_seq #(
  parameter int W   = 4,
  parameter int N   = 8,
  parameter int LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sum_of_squares_seq_if.slave    bus
);

  localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int NP1 = N + 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_acc;
  logic [CW-1:0]   r_count;
  logic            r_ready;
  logic            r_done;
  logic            r_busy;
  logic            r_ovf;

  // Zero-extend before multiplying so the full 2W-bit product is kept.
  logic [2*W-1:0]  w_a_ext;
  logic [2*W-1:0]  w_sq;
  logic [N:0]      w_sum;

  always_comb begin
    w_a_ext = {{W{1'b0}}, bus.A};
    w_sq    = w_a_ext * w_a_ext;
    // One extra bit captures the carry-out that feeds the sticky overflow flag.
    w_sum   = {1'b0, r_acc} + NP1'(w_sq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.start) begin
      // start wins over everything, including an element presented in the same cycle.
      r_state <= S_ACCUM;
      r_acc   <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_ACCUM: begin
          if (bus.in_valid) begin
            r_acc <= w_sum[N-1:0];
            r_ovf <= r_ovf | w_sum[N];
            if (r_count == LAST) begin
              r_state <= S_DONE;
              r_count <= '0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: begin
          // IDLE / DONE: elements are ignored, result and flags held.
        end
      endcase
    end
  end

  assign bus.O          = r_acc;
  assign bus.ready      = r_ready;
  assign bus.done_pulse = r_done;
  assign bus.busy       = r_busy;
  assign bus.overflow   = r_ovf;

endmodule

// File: doc/sum_of_squares_seq.md
Name: sum_of_squares_seq

Overview:
- Sequential accumulator sitting directly upstream of the sequential square-root stage.
- Accepts a stream of LEN unsigned elements, one per valid cycle, and accumulates the sum of their squares into an N-bit result (squared Euclidean norm).
- When all LEN elements are accumulated, it presents the result with a level ready and a one-cycle done_pulse, so the square-root stage can be started directly (done_pulse -> its start, O -> its A).

Parameters:
- W, 4, element width in bits (unsigned).
- N, 8, accumulator/result width; must be even, N >= 2*W.
- LEN, 4, number of elements per vector; LEN >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new vector (clears accumulator); priority over all other inputs.
- in_valid  input  1  A carries a valid element this cycle.
- A  input  W  unsigned element.
- O  output  N  accumulated sum of squares (mod 2^N).
- ready  output  1  level: O holds a final result; held until next start or rst.
- done_pulse  output  1  single-cycle pulse coincident with ready rising.
- busy  output  1  high while in ACCUM.
- overflow  output  1  sticky: some addition carried out of N bits during this vector.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, count=0, O=0, ready=0, done_pulse=0, busy=0, overflow=0. Reset mid-vector discards all progress.
- States: IDLE, ACCUM, DONE. busy=1 only in ACCUM.
- Any state, start=1: acc<=0, count<=0, overflow<=0, ready<=0, done_pulse<=0, state<=ACCUM. in_valid in the same cycle is ignored (element dropped).
- ACCUM, start=0, in_valid=1:
  - sq = A*A, 2W bits, zero-extended to N+1 bits.
  - sum = acc + sq, N+1 bits.
  - acc<=sum[N-1:0]; overflow<=overflow|sum[N].
  - count<=count+1.
- ACCUM, in_valid=0: hold everything (gaps are allowed, with no limit on length).
- On the edge accepting the LEN-th element (count==LEN-1 && in_valid):
  - acc and overflow are updated as above.
  - ready<=1, done_pulse<=1, state<=DONE, count<=0.
  - Latency: result visible one cycle after the last element is presented.
- done_pulse is forced to 0 on the following edge, unless that edge carries start (start clears it anyway).
- IDLE/DONE: in_valid ignored; O, ready and overflow are held.
- O is driven directly from acc. Intermediate values are visible during ACCUM; only values with ready=1 are final.
- count width: ceil(log2(LEN)), minimum 1 bit. No wrap occurs because the transition to DONE resets count.
- Arithmetic is modulo 2^N. overflow is the only indication of a wrapped result; no saturation.
- Back-to-back vectors: start may be asserted in the same cycle as done_pulse is high. The new vector begins and ready drops on that edge.

Test Plan:
- Basic, W=4,N=8,LEN=4: rst, start, then A=3,4,0,0 with in_valid on 4 consecutive cycles -> one cycle later O=25, ready=1, done_pulse=1 for exactly 1 cycle, overflow=0, busy=0; with a connected square-root stage, its output is 5.
- Gaps: start, then A=1,2,2,4 with in_valid deasserted 3 cycles between each -> O=25 only after the 4th element, ready stays 0 until then.
- Overflow: start, then A=15,15,1,0 -> O=(225+225+1) mod 256=195, overflow=1, ready=1; next start clears overflow to 0.
- start priority and restart: mid-vector (after A=7,7), assert start together with in_valid (A=9) -> acc=0, count=0, element 9 dropped; then A=1,1,1,1 -> O=4.
- Async reset mid-vector: after 2 elements assert rst between clock edges -> all outputs 0 immediately, state IDLE; in_valid without start -> no change.
- Back-to-back with LEN=1: start, A=6 -> O=36, ready, done_pulse. In the done_pulse cycle assert start, then A=2 -> ready drops for one cycle, then O=4, ready=1.
